// File: rtl/axis_sc16_sat_monitor_if.sv
// rtl/axis_sc16_sat_monitor_if.sv - sc16 AXI-Stream bundle for the saturation monitor
//
// One stream link: tdata (I = [31:16], Q = [15:0], signed sc16), tlast,
// tvalid, tready. The master drives data/last/valid; the slave drives ready.
interface axis_sc16_sat_monitor_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_sc16_sat_monitor.sv
// rtl/axis_sc16_sat_monitor.sv - sc16 pass-through with clipping statistics
//
// Sits after the gain multiplier. Every sample is forwarded unmodified through
// a 2-entry skid buffer while clipping statistics are gathered on the input
// handshake, so the statistics do not depend on output backpressure.
//
// Ports:
//   clk                clock (the only clock)
//   rst                asynchronous active-high reset
//   s_axis             stream input (slave side)
//   m_axis             stream output (master side), bit-identical to input
//   clear_i            single-cycle pulse zeroing all statistics
//   pkt_sat_count_o    saturated samples in the last completed packet
//   pkt_sat_valid_o    one-cycle strobe: pkt_sat_count_o just updated
//   total_sat_count_o  saturated samples since reset/clear (saturating)
//   total_pkt_count_o  packets since reset/clear (saturating)
//   peak_mag_o         max |I|,|Q| since reset/clear, 0..0x7FFF
module axis_sc16_sat_monitor #(
    parameter int CNT_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    axis_sc16_sat_monitor_if.slave         s_axis,
    axis_sc16_sat_monitor_if.master        m_axis,
    input  logic                           clear_i,
    output logic [15:0]                    pkt_sat_count_o,
    output logic                           pkt_sat_valid_o,
    output logic [CNT_W-1:0]               total_sat_count_o,
    output logic [CNT_W-1:0]               total_pkt_count_o,
    output logic [15:0]                    peak_mag_o
);

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        tready_q, tready_d;
    logic [31:0] out_tdata_q, out_tdata_d;
    logic        out_tlast_q, out_tlast_d;
    logic [31:0] skid_tdata_q, skid_tdata_d;
    logic        skid_tlast_q, skid_tlast_d;

    logic accept;
    logic pop;

    assign accept = s_axis.tvalid & tready_q;
    assign pop    = (state_q != ST_EMPTY) & m_axis.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            tready_q     <= 1'b0;
            out_tdata_q  <= 32'd0;
            out_tlast_q  <= 1'b0;
            skid_tdata_q <= 32'd0;
            skid_tlast_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
            skid_tdata_q <= skid_tdata_d;
            skid_tlast_q <= skid_tlast_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        skid_tdata_d = skid_tdata_q;
        skid_tlast_d = skid_tlast_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_tdata_d = s_axis.tdata;
                    out_tlast_d = s_axis.tlast;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        // Output stalled: park the new beat behind the head.
                        skid_tdata_d = s_axis.tdata;
                        skid_tlast_d = s_axis.tlast;
                        state_d      = ST_TWO;
                    end
                    2'b01: state_d = ST_EMPTY;
                    2'b11: begin
                        out_tdata_d = s_axis.tdata;
                        out_tlast_d = s_axis.tlast;
                    end
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (pop) begin
                    out_tdata_d = skid_tdata_q;
                    out_tlast_d = skid_tlast_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Ready is registered from the next state, so there is no
        // combinational path from m_axis.tready to s_axis.tready.
        tready_d = (state_d != ST_TWO);
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = (state_q != ST_EMPTY);
    assign m_axis.tdata  = out_tdata_q;
    assign m_axis.tlast  = out_tlast_q;

    // ------------------------------------------------------------------
    // Clipping statistics
    // ------------------------------------------------------------------
    function automatic logic [15:0] mag16(input logic [15:0] x);
        logic [15:0] r;
        if (x == 16'h8000) begin
            r = 16'h7FFF;          // -32768 has no positive twin in 16 bits
        end else if (x[15]) begin
            r = 16'd0 - x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic [15:0] samp_i;
    logic [15:0] samp_q;
    logic        sat_beat;
    logic [15:0] mag_i;
    logic [15:0] mag_q;
    logic [15:0] beat_mag;
    logic [15:0] pkt_sum;

    assign samp_i   = s_axis.tdata[31:16];
    assign samp_q   = s_axis.tdata[15:0];
    assign sat_beat = (samp_i == 16'h7FFF) | (samp_i == 16'h8000) |
                      (samp_q == 16'h7FFF) | (samp_q == 16'h8000);
    assign mag_i    = mag16(samp_i);
    assign mag_q    = mag16(samp_q);
    assign beat_mag = (mag_i > mag_q) ? mag_i : mag_q;

    logic [15:0]      pkt_acc_q, pkt_acc_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             pkt_vld_q, pkt_vld_d;
    logic [CNT_W-1:0] tot_sat_q, tot_sat_d;
    logic [CNT_W-1:0] tot_pkt_q, tot_pkt_d;
    logic [15:0]      peak_q, peak_d;

    // Packet accumulator including this beat, pinned at 0xFFFF.
    assign pkt_sum = (pkt_acc_q == 16'hFFFF) ? 16'hFFFF
                                             : pkt_acc_q + 16'(sat_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_acc_q <= 16'd0;
            pkt_cnt_q <= 16'd0;
            pkt_vld_q <= 1'b0;
            tot_sat_q <= '0;
            tot_pkt_q <= '0;
            peak_q    <= 16'd0;
        end else begin
            pkt_acc_q <= pkt_acc_d;
            pkt_cnt_q <= pkt_cnt_d;
            pkt_vld_q <= pkt_vld_d;
            tot_sat_q <= tot_sat_d;
            tot_pkt_q <= tot_pkt_d;
            peak_q    <= peak_d;
        end
    end

    always_comb begin
        pkt_acc_d = pkt_acc_q;
        pkt_cnt_d = pkt_cnt_q;
        pkt_vld_d = 1'b0;
        tot_sat_d = tot_sat_q;
        tot_pkt_d = tot_pkt_q;
        peak_d    = peak_q;
        if (clear_i) begin
            // A beat accepted alongside clear is forwarded but not counted,
            // and a tlast on it raises no strobe.
            pkt_acc_d = 16'd0;
            pkt_cnt_d = 16'd0;
            tot_sat_d = '0;
            tot_pkt_d = '0;
            peak_d    = 16'd0;
        end else if (accept) begin
            if (sat_beat && (tot_sat_q != CNT_ONES)) begin
                tot_sat_d = tot_sat_q + CNT_W'(1);
            end
            if (beat_mag > peak_q) begin
                peak_d = beat_mag;
            end
            if (s_axis.tlast) begin
                pkt_cnt_d = pkt_sum;
                pkt_acc_d = 16'd0;
                pkt_vld_d = 1'b1;
                if (tot_pkt_q != CNT_ONES) begin
                    tot_pkt_d = tot_pkt_q + CNT_W'(1);
                end
            end else begin
                pkt_acc_d = pkt_sum;
            end
        end
    end

    assign pkt_sat_count_o   = pkt_cnt_q;
    assign pkt_sat_valid_o   = pkt_vld_q;
    assign total_sat_count_o = tot_sat_q;
    assign total_pkt_count_o = tot_pkt_q;
    assign peak_mag_o        = peak_q;

endmodule

// File: tb/tb_axis_sc16_sat_monitor.sv
// tb/tb_axis_sc16_sat_monitor.sv - randomized self-checking bench for axis_sc16_sat_monitor
module tb_axis_sc16_sat_monitor;

    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_sc16_sat_monitor_if s_if ();
    axis_sc16_sat_monitor_if m_if ();

    logic             clear;
    logic [15:0]      pkt_sat_count;
    logic             pkt_sat_valid;
    logic [CNT_W-1:0] total_sat_count;
    logic [CNT_W-1:0] total_pkt_count;
    logic [15:0]      peak_mag;

    axis_sc16_sat_monitor #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .clear_i           (clear),
        .pkt_sat_count_o   (pkt_sat_count),
        .pkt_sat_valid_o   (pkt_sat_valid),
        .total_sat_count_o (total_sat_count),
        .total_pkt_count_o (total_pkt_count),
        .peak_mag_o        (peak_mag)
    );

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [32:0] mq[$];        // {tlast, tdata} in flight, FIFO order
    bit  m_ready;              // expected s_axis.tready
    bit  mdl_acc;              // input handshake at the latest edge
    bit  m_pkt_vld;
    int  m_pkt_acc, m_pkt_cnt, m_tot_sat, m_tot_pkt, m_peak;
    bit  b_acc, b_pop, b_sat;
    int  b_mag;

    function automatic bit is_sat(input logic [31:0] d);
        return d[31:16] == 16'h7FFF || d[31:16] == 16'h8000 ||
               d[15:0]  == 16'h7FFF || d[15:0]  == 16'h8000;
    endfunction

    function automatic int mag(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_ready = 0; mdl_acc = 0; m_pkt_vld = 0;
            m_pkt_acc = 0; m_pkt_cnt = 0; m_tot_sat = 0; m_tot_pkt = 0; m_peak = 0;
        end else begin
            b_acc = s_if.tvalid && m_ready;
            b_pop = (mq.size() > 0) && m_if.tready;
            if (b_pop) void'(mq.pop_front());
            if (b_acc) mq.push_back({s_if.tlast, s_if.tdata});
            m_ready   = mq.size() < 2;
            mdl_acc   = b_acc;
            m_pkt_vld = 0;
            if (clear) begin
                m_pkt_acc = 0; m_pkt_cnt = 0; m_tot_sat = 0; m_tot_pkt = 0; m_peak = 0;
            end else if (b_acc) begin
                b_sat = is_sat(s_if.tdata);
                b_mag = mag(s_if.tdata[31:16]);
                if (mag(s_if.tdata[15:0]) > b_mag) b_mag = mag(s_if.tdata[15:0]);
                if (b_mag > m_peak) m_peak = b_mag;
                m_tot_sat = min2(m_tot_sat + int'(b_sat), CMAX);
                m_pkt_acc = min2(m_pkt_acc + int'(b_sat), 65535);
                if (s_if.tlast) begin
                    m_pkt_cnt = m_pkt_acc;
                    m_pkt_acc = 0;
                    m_pkt_vld = 1;
                    m_tot_pkt = min2(m_tot_pkt + 1, CMAX);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (pkt_sat_valid === 1'b1) pulse_cnt++;
        if (rst) begin
            chk("rst_s_tready", s_if.tready, 0);
            chk("rst_m_tvalid", m_if.tvalid, 0);
            chk("rst_m_tdata", m_if.tdata, 0);
            chk("rst_m_tlast", m_if.tlast, 0);
            chk("rst_pkt_valid", pkt_sat_valid, 0);
            chk("rst_pkt_cnt", pkt_sat_count, 0);
            chk("rst_tot_sat", total_sat_count, 0);
            chk("rst_tot_pkt", total_pkt_count, 0);
            chk("rst_peak", peak_mag, 0);
        end else begin
            chk("s_tready", s_if.tready, m_ready);
            chk("m_tvalid", m_if.tvalid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_tdata", m_if.tdata, mq[0][31:0]);
                chk("m_tlast", m_if.tlast, mq[0][32]);
            end
            chk("pkt_sat_valid", pkt_sat_valid, m_pkt_vld);
            chk("pkt_sat_count", pkt_sat_count, m_pkt_cnt);
            chk("total_sat", total_sat_count, m_tot_sat);
            chk("total_pkt", total_pkt_count, m_tot_pkt);
            chk("peak_mag", peak_mag, m_peak);
        end
    end

    // ---------------- output ready driver ----------------
    bit rnd_mode   = 0;
    bit fixed_rdy  = 1;
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rnd_mode ? ($urandom_range(0, 3) != 0) : fixed_rdy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_beat(input logic [31:0] d, input logic l, input logic c);
        int n;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        clear       = c;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mdl_acc && n < 1000);
        if (!mdl_acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout @%0t: got no handshake, expected one within 1000 cycles", $time);
        end
        s_if.tvalid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] rd;
    int          left, plen;

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'd0;
        s_if.tlast  = 1'b0;
        clear       = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_release", s_if.tready, 1);

        // 64 small samples, one packet
        for (int i = 0; i < 64; i++) begin
            send_beat(32'h0010_0010, i == 63, 1'b0);
            if (i == 0) begin
                chk("first_latency_valid", m_if.tvalid, 1);
                chk("first_latency_data", m_if.tdata, 32'h0010_0010);
            end
        end
        idle(2);
        chk("t1_pkt_sat", pkt_sat_count, 0);
        chk("t1_tot_pkt", total_pkt_count, 1);
        chk("t1_peak", peak_mag, 16'h0010);
        chk("t1_tot_sat", total_sat_count, 0);

        // 8-sample packet with 3 saturated beats
        pulse_cnt = 0;
        send_beat(32'h7FFF_0000, 1'b0, 1'b0);
        send_beat(32'h0000_8000, 1'b0, 1'b0);
        send_beat(32'h7FFF_8000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(32'h0100_0100, i == 4, 1'b0);
        idle(3);
        chk("t2_pkt_sat", pkt_sat_count, 3);
        chk("t2_tot_sat", total_sat_count, 3);
        chk("t2_peak", peak_mag, 16'h7FFF);
        chk("t2_pulses", pulse_cnt, 1);
        chk("t2_tot_pkt", total_pkt_count, 2);

        // randomized traffic with 25% output stalls
        rnd_mode = 1;
        left = 1000;
        while (left > 0) begin
            plen = $urandom_range(1, 20);
            if (plen > left) plen = left;
            for (int b = 0; b < plen; b++) begin
                rd = $urandom;
                case ($urandom_range(0, 7))
                    0: rd[31:16] = 16'h7FFF;
                    1: rd[31:16] = 16'h8000;
                    2: rd[15:0]  = 16'h7FFF;
                    3: rd[15:0]  = 16'h8000;
                    default: ;
                endcase
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                send_beat(rd, b == plen - 1, 1'b0);
            end
            left -= plen;
        end
        rnd_mode  = 0;
        fixed_rdy = 1;
        idle(6);

        // clear on the tlast beat of a packet with 2 saturated samples
        pulse_cnt = 0;
        send_beat(32'h7FFF_0001, 1'b0, 1'b0);
        send_beat(32'h0001_8000, 1'b0, 1'b0);
        send_beat(32'h0002_0002, 1'b1, 1'b1);
        idle(3);
        chk("t4_pulses", pulse_cnt, 0);
        chk("t4_pkt_sat", pkt_sat_count, 0);
        chk("t4_tot_sat", total_sat_count, 0);
        chk("t4_tot_pkt", total_pkt_count, 0);
        chk("t4_peak", peak_mag, 0);

        // 70000 saturated samples in one packet: counters must pin
        pulse_cnt = 0;
        for (int i = 0; i < 70000; i++)
            send_beat((i % 2) ? 32'h0000_8000 : 32'h7FFF_0000, i == 69999, 1'b0);
        idle(3);
        chk("t5_pkt_sat", pkt_sat_count, 16'hFFFF);
        chk("t5_tot_sat", total_sat_count, CMAX);
        chk("t5_tot_pkt", total_pkt_count, 1);
        chk("t5_pulses", pulse_cnt, 1);

        // reset with two samples buffered
        fixed_rdy = 0;
        idle(2);
        send_beat(32'h7FFF_7FFF, 1'b0, 1'b0);
        send_beat(32'h8000_1234, 1'b0, 1'b0);
        chk("t6_full_tready", s_if.tready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_m_tvalid", m_if.tvalid, 0);
        chk("t6_rst_s_tready", s_if.tready, 0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        fixed_rdy = 1;
        idle(5);
        chk("t6_no_stale", m_if.tvalid, 0);
        chk("t6_tot_sat", total_sat_count, 0);
        chk("t6_peak", peak_mag, 0);
        chk("t6_pkt_sat", pkt_sat_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_sc16_sat_monitor.md
# axis_sc16_sat_monitor

- AXI-Stream sc16 pass-through monitor placed directly downstream of the gain core, between the gain multiplier output and the noc_shell data output.
- Forwards every sample unmodified through a 2-entry skid buffer.
- Measures clipping produced by the gain stage: per-packet and cumulative saturated-sample counts, plus a running peak magnitude.
- Statistics feed read-only block registers so host software can detect gain settings that clip.

## Interface
Parameters:
- CNT_W, 32, width of cumulative counters (16..32)

Ports (name, direction, width, meaning):
- clk  in  1  data clock; the only clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  32  sample input; I = [31:16], Q = [15:0], signed sc16
- s_axis_tlast  in  1  last sample of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  32  sample output, bit-identical to input
- m_axis_tlast  out  1  forwarded tlast
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- clear  in  1  single-cycle pulse; zeroes all statistics
- pkt_sat_count  out  16  saturated samples in the last completed packet
- pkt_sat_valid  out  1  one-cycle strobe; pkt_sat_count updated
- total_sat_count  out  CNT_W  saturated samples since reset/clear
- total_pkt_count  out  CNT_W  packets (tlast beats) since reset/clear
- peak_mag  out  16  max of |I|,|Q| since reset/clear; range 0..0x7FFF

## Operation
Saturation rule:
- A sample is saturated if I or Q equals 0x7FFF or 0x8000.
- It counts once even if both I and Q are saturated.

Magnitude rule:
- |x| in 16 bits; |0x8000| clips to 0x7FFF.
- peak_mag = max(peak_mag, |I|, |Q|).

Statistics update point:
- All statistics update on an input handshake (s_axis_tvalid & s_axis_tready), never on output.

Per-packet accumulator pkt_acc (16 bit):
- Increments per saturated beat and saturates at 0xFFFF.
- On a tlast beat, pkt_sat_count <= pkt_acc + this beat's contribution (saturating), pkt_acc <= 0, and pkt_sat_valid pulses.

Cumulative counters:
- total_sat_count and total_pkt_count saturate at all-ones and never wrap.

clear:
- clear zeroes total_sat_count, total_pkt_count, peak_mag, pkt_acc and pkt_sat_count.
- A beat accepted in the same cycle as clear is forwarded but excluded from all statistics.
- If that beat carries tlast, no pkt_sat_valid pulse is produced.

Skid buffer states:
- EMPTY: tready=1, m_tvalid=0.
  - Accept → ONE.
- ONE: tready=1, m_tvalid=1.
  - Accept without output → TWO.
  - Output without accept → EMPTY.
  - Both → ONE.
- TWO: tready=0, m_tvalid=1.
  - Output → ONE.

Buffer rules:
- Output order is strictly FIFO; tdata and tlast travel together.
- s_axis_tready is a register output with no combinational path from m_axis_tready.

## Timing
Reset values (while rst is high):
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_sat_valid=0.
- All counters, peak_mag and pkt_sat_count = 0.

Reset release:
- State EMPTY.
- s_axis_tready=1 from the first rising edge after rst falls.

Latency and throughput:
- Input handshake at edge N → m_axis_tvalid=1 with that data after edge N.
- Sustained throughput is 1 sample/cycle while m_axis_tready=1.

Statistics timing:
- Statistics registers reflect a beat accepted at edge N after edge N.
- pkt_sat_valid is high for exactly the cycle following the tlast accept.

Handshake rules:
- m_axis_tvalid, once asserted, holds with stable tdata/tlast until m_axis_tready.
- Statistics are independent of output backpressure.

Reset mid-packet:
- Buffered samples are discarded and the partial packet count is lost.

## Test plan
- Reset, then 64-sample packet with all samples 0x00100010 and m_tready=1 → output identical, 1-cycle latency, pkt_sat_count=0, total_pkt_count=1, peak_mag=0x0010.
- Packet of 8 samples: 0x7FFF0000, 0x00008000, 0x7FFF8000, then 5× 0x01000100 → pkt_sat_count=3 with one pkt_sat_valid pulse; total_sat_count=3; peak_mag=0x7FFF.
- Random m_tready with 25% stall probability and random s_tvalid over 1000 samples → output sequence bit-exact with input, no loss or duplication, s_tready never high in state TWO.
- clear asserted coincident with the tlast beat of a packet containing 2 saturated samples → data forwarded, no pkt_sat_valid pulse, all statistics 0 afterwards.
- Preload total_sat_count near all-ones (CNT_W=16), send 70000 saturated samples → count holds at 0xFFFF with no wrap; a 70000-sample single packet reports pkt_sat_count=0xFFFF.
- Assert rst with 2 samples buffered (m_tready=0) → m_tvalid drops to 0 immediately; after release no stale samples emerge and all statistics are 0.
